// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, fills the IF/ID register.
// Define IF_PERF_COUNTERS_EN to add the saturating FETCH_COUNT/BUBBLE_COUNT outputs.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_WIDTH = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] PC,
    input  logic [31:0] INSTRUCTION,
    input  logic        IMEM_BUSYWAIT,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC4,
    output logic [31:0] IFID_INSTRUCTION,
    output logic        IFID_VALID,
    output logic        FETCH_MISALIGN
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [CNT_WIDTH-1:0] FETCH_COUNT,
    output logic [CNT_WIDTH-1:0] BUBBLE_COUNT
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        misalign_q, misalign_d;
    logic        load_fetch;
    logic        load_bubble;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        misalign_d   = 1'b0;
        load_fetch   = 1'b0;
        load_bubble  = 1'b0;
        if (BRANCH_TAKEN) begin
            // In-flight fetch is dropped; the target word is fetched fresh.
            pc_d         = {BRANCH_TARGET[31:2], 2'b00};
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            misalign_d   = |BRANCH_TARGET[1:0];
            state_d      = FETCH;
            load_bubble  = 1'b1;
        end else if (FLUSH) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            load_bubble  = 1'b1;
            if (!IMEM_BUSYWAIT && !STALL) pc_d = pc_plus4;
            state_d = IMEM_BUSYWAIT ? WAIT : FETCH;
        end else if (STALL) begin
            state_d = IMEM_BUSYWAIT ? WAIT : FETCH;
        end else if (IMEM_BUSYWAIT) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            state_d      = WAIT;
            load_bubble  = 1'b1;
        end else begin
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = INSTRUCTION;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4;
            state_d      = FETCH;
            load_fetch   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign PC               = pc_q;
    assign IFID_PC          = ifid_pc_q;
    assign IFID_PC4         = ifid_pc4_q;
    assign IFID_INSTRUCTION = ifid_instr_q;
    assign IFID_VALID       = ifid_valid_q;
    assign FETCH_MISALIGN   = misalign_q;

`ifdef IF_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (load_fetch && (fetch_cnt_q != '1))
            fetch_cnt_d = fetch_cnt_q + 1'b1;
        if (load_bubble && (bubble_cnt_q != '1))
            bubble_cnt_d = bubble_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign FETCH_COUNT  = fetch_cnt_q;
    assign BUBBLE_COUNT = bubble_cnt_q;
`else
    logic [CNT_WIDTH-1:0] unused_cnt;
    logic                 unused_flags;
    assign unused_cnt   = '0;
    assign unused_flags = load_fetch ^ load_bubble;
`endif

endmodule
